// File: rtl/axis_xform_stream.sv
// rtl/axis_xform_stream.sv - AXI-Stream wrapper around a fixed-latency transform core
// Tracks beat sideband next to the core, buffers results in a FWFT FIFO and emits byte-count status.
module axis_xform_stream #(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_CORE_LAT   = 29,
  parameter int C_FIFO_DEPTH = 256,
  parameter int C_STS_WORDS  = 5,
  parameter int C_LEN_DEPTH  = 4
) (
  input  logic                      m_axi_mm2s_aclk,
  input  logic                      axi_resetn,
  input  logic [C_DATA_WIDTH-1:0]   m_axis_mm2s_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] m_axis_mm2s_tkeep,
  input  logic                      m_axis_mm2s_tvalid,
  input  logic                      m_axis_mm2s_tlast,
  output logic                      m_axis_mm2s_tready,
  output logic [C_DATA_WIDTH-1:0]   core_din,
  output logic                      core_din_vld,
  input  logic [C_DATA_WIDTH-1:0]   core_dout,
  output logic [C_DATA_WIDTH-1:0]   s_axis_s2mm_tdata,
  output logic [C_DATA_WIDTH/8-1:0] s_axis_s2mm_tkeep,
  output logic                      s_axis_s2mm_tvalid,
  output logic                      s_axis_s2mm_tlast,
  input  logic                      s_axis_s2mm_tready,
  output logic [31:0]               s_axis_s2mm_sts_tdata,
  output logic [3:0]                s_axis_s2mm_sts_tkeep,
  output logic                      s_axis_s2mm_sts_tvalid,
  output logic                      s_axis_s2mm_sts_tlast,
  input  logic                      s_axis_s2mm_sts_tready,
  input  logic                      s2mm_intr,
  input  logic                      mm2s_intr,
  output logic                      axi_intr
);

  localparam int KW  = C_DATA_WIDTH / 8;
  localparam int AW  = $clog2(C_FIFO_DEPTH);
  localparam int CW  = AW + 2;
  localparam int FW  = C_DATA_WIDTH + KW + 1;
  localparam int LW  = $clog2(C_LEN_DEPTH);
  localparam int LCW = LW + 1;
  localparam logic [3:0] LAST_WORD = 4'(C_STS_WORDS - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_SEND} sts_state_e;

  logic                         tready_q, tready_d;
  logic [C_DATA_WIDTH-1:0]      core_din_q, core_din_d;
  logic [C_CORE_LAT:0]          dl_vld_q, dl_vld_d;
  logic [C_CORE_LAT:0][KW:0]    dl_kl_q, dl_kl_d;
  logic [CW-1:0]                infl_q, infl_d;
  logic [CW-1:0]                fcnt_q, fcnt_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [23:0]                  cnt_q, cnt_d;
  logic                         sat_q, sat_d;
  logic [LW-1:0]                lwr_ptr_q, lwr_ptr_d;
  logic [LW-1:0]                lrd_ptr_q, lrd_ptr_d;
  logic [LCW-1:0]               lcnt_q, lcnt_d;
  sts_state_e                   state_q, state_d;
  logic [3:0]                   widx_q, widx_d;

  logic [FW-1:0]                fifo_mem [C_FIFO_DEPTH];
  logic [24:0]                  len_mem  [C_LEN_DEPTH];

  logic                         in_hs, fifo_wr, fifo_rd, fifo_empty, head_last;
  logic                         len_full, len_push, len_pop;
  logic [KW:0]                  kl_in;
  logic [FW-1:0]                head;
  logic [24:0]                  pc, byte_sum, len_in, len_head;
  logic [23:0]                  cnt_sat;
  logic                         sat_new;

  assign in_hs              = m_axis_mm2s_tvalid & tready_q;
  assign kl_in              = in_hs ? {m_axis_mm2s_tkeep, m_axis_mm2s_tlast} : '0;
  assign m_axis_mm2s_tready = tready_q;
  assign core_din           = core_din_q;
  assign core_din_vld       = dl_vld_q[0];
  assign fifo_wr            = dl_vld_q[C_CORE_LAT];

  assign head               = fifo_mem[rd_ptr_q];
  assign head_last          = head[0];
  assign fifo_empty         = (fcnt_q == '0);
  assign len_full           = (lcnt_q == LCW'(C_LEN_DEPTH));
  // A tlast beat waits until the len queue can take its byte count.
  assign s_axis_s2mm_tvalid = !fifo_empty && !(head_last && len_full);
  assign s_axis_s2mm_tdata  = head[FW-1 -: C_DATA_WIDTH];
  assign s_axis_s2mm_tkeep  = head[KW:1];
  assign s_axis_s2mm_tlast  = head_last;
  assign fifo_rd            = s_axis_s2mm_tvalid & s_axis_s2mm_tready;
  assign len_push           = fifo_rd & head_last;

  assign len_head              = len_mem[lrd_ptr_q];
  assign s_axis_s2mm_sts_tkeep = 4'hf;
  assign s_axis_s2mm_sts_tdata = (widx_q == 4'd0) ? {4'h5, 3'b000, len_head} : 32'h0;
  assign s_axis_s2mm_sts_tlast = (state_q == ST_SEND) && (widx_q == LAST_WORD);
  assign len_pop               = s_axis_s2mm_sts_tvalid & s_axis_s2mm_sts_tready &
                                 (widx_q == LAST_WORD);
  assign axi_intr              = s2mm_intr | mm2s_intr;

  always_comb begin
    core_din_d = in_hs ? m_axis_mm2s_tdata : core_din_q;
    dl_vld_d   = {dl_vld_q[C_CORE_LAT-1:0], in_hs};
    dl_kl_d    = {dl_kl_q[C_CORE_LAT-1:0], kl_in};
    infl_d     = infl_q + CW'(in_hs) - CW'(fifo_wr);
    fcnt_d     = fcnt_q + CW'(fifo_wr) - CW'(fifo_rd);
    wr_ptr_d   = wr_ptr_q + AW'(fifo_wr);
    rd_ptr_d   = rd_ptr_q + AW'(fifo_rd);
    // Registered ready looks at next-cycle occupancy so one more accept can never overflow.
    tready_d   = (fcnt_d + infl_d) < CW'(C_FIFO_DEPTH);
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < KW; i++) begin
      pc = pc + 25'(s_axis_s2mm_tkeep[i]);
    end
    byte_sum = {1'b0, cnt_q} + pc;
    cnt_sat  = byte_sum[24] ? 24'hFFFFFF : byte_sum[23:0];
    sat_new  = sat_q | byte_sum[24];
    len_in   = {sat_new, cnt_sat};
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    if (fifo_rd) begin
      if (head_last) begin
        cnt_d = '0;
        sat_d = 1'b0;
      end else begin
        cnt_d = cnt_sat;
        sat_d = sat_new;
      end
    end
    lwr_ptr_d = lwr_ptr_q + LW'(len_push);
    lrd_ptr_d = lrd_ptr_q + LW'(len_pop);
    lcnt_d    = lcnt_q + LCW'(len_push) - LCW'(len_pop);
  end

  always_comb begin
    state_d                = state_q;
    widx_d                 = widx_q;
    s_axis_s2mm_sts_tvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lcnt_q != '0) begin
          state_d = ST_SEND;
          widx_d  = 4'd0;
        end
      end
      ST_SEND: begin
        s_axis_s2mm_sts_tvalid = 1'b1;
        if (s_axis_s2mm_sts_tready) begin
          if (widx_q == LAST_WORD) begin
            state_d = ST_IDLE;
            widx_d  = 4'd0;
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_mm2s_aclk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= {core_dout, dl_kl_q[C_CORE_LAT]};
    if (len_push) len_mem[lwr_ptr_q] <= len_in;
  end

  always_ff @(posedge m_axi_mm2s_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      tready_q   <= 1'b0;
      core_din_q <= '0;
      dl_vld_q   <= '0;
      dl_kl_q    <= '0;
      infl_q     <= '0;
      fcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      lwr_ptr_q  <= '0;
      lrd_ptr_q  <= '0;
      lcnt_q     <= '0;
      state_q    <= ST_IDLE;
      widx_q     <= '0;
    end else begin
      tready_q   <= tready_d;
      core_din_q <= core_din_d;
      dl_vld_q   <= dl_vld_d;
      dl_kl_q    <= dl_kl_d;
      infl_q     <= infl_d;
      fcnt_q     <= fcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      lwr_ptr_q  <= lwr_ptr_d;
      lrd_ptr_q  <= lrd_ptr_d;
      lcnt_q     <= lcnt_d;
      state_q    <= state_d;
      widx_q     <= widx_d;
    end
  end

endmodule

// File: tb/tb_axis_xform_stream.sv
// tb/tb_axis_xform_stream.sv - self-checking bench for axis_xform_stream
// Models the core as a fixed-latency pipeline; scoreboards data beats and status packets.
module tb_axis_xform_stream;

  localparam int C_DW    = 128;
  localparam int C_LAT   = 29;
  localparam int C_DEPTH = 256;
  localparam int C_STS   = 5;
  localparam int WD_CYCLES = 90000;

  typedef struct { logic [127:0] d; logic [15:0] k; logic l; } beat_t;
  typedef struct { int n; logic [15:0] lk; int cnt; } pkt_vec_t;
  typedef struct { logic a; logic b; logic y; } intr_vec_t;

  logic clk = 1'b0;
  logic axi_resetn;
  logic [127:0] m_axis_mm2s_tdata;
  logic [15:0]  m_axis_mm2s_tkeep;
  logic         m_axis_mm2s_tvalid, m_axis_mm2s_tlast, m_axis_mm2s_tready;
  logic [127:0] core_din, core_dout;
  logic         core_din_vld;
  logic [127:0] s_axis_s2mm_tdata;
  logic [15:0]  s_axis_s2mm_tkeep;
  logic         s_axis_s2mm_tvalid, s_axis_s2mm_tlast;
  logic         s_axis_s2mm_tready = 1'b0;
  logic [31:0]  s_axis_s2mm_sts_tdata;
  logic [3:0]   s_axis_s2mm_sts_tkeep;
  logic         s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tlast;
  logic         s_axis_s2mm_sts_tready = 1'b0;
  logic         s2mm_intr, mm2s_intr, axi_intr;

  axis_xform_stream #(.C_DATA_WIDTH(C_DW), .C_CORE_LAT(C_LAT), .C_FIFO_DEPTH(C_DEPTH),
                      .C_STS_WORDS(C_STS), .C_LEN_DEPTH(4)) dut (
    .m_axi_mm2s_aclk(clk), .axi_resetn(axi_resetn),
    .m_axis_mm2s_tdata(m_axis_mm2s_tdata), .m_axis_mm2s_tkeep(m_axis_mm2s_tkeep),
    .m_axis_mm2s_tvalid(m_axis_mm2s_tvalid), .m_axis_mm2s_tlast(m_axis_mm2s_tlast),
    .m_axis_mm2s_tready(m_axis_mm2s_tready),
    .core_din(core_din), .core_din_vld(core_din_vld), .core_dout(core_dout),
    .s_axis_s2mm_tdata(s_axis_s2mm_tdata), .s_axis_s2mm_tkeep(s_axis_s2mm_tkeep),
    .s_axis_s2mm_tvalid(s_axis_s2mm_tvalid), .s_axis_s2mm_tlast(s_axis_s2mm_tlast),
    .s_axis_s2mm_tready(s_axis_s2mm_tready),
    .s_axis_s2mm_sts_tdata(s_axis_s2mm_sts_tdata), .s_axis_s2mm_sts_tkeep(s_axis_s2mm_sts_tkeep),
    .s_axis_s2mm_sts_tvalid(s_axis_s2mm_sts_tvalid), .s_axis_s2mm_sts_tlast(s_axis_s2mm_sts_tlast),
    .s_axis_s2mm_sts_tready(s_axis_s2mm_sts_tready),
    .s2mm_intr(s2mm_intr), .mm2s_intr(mm2s_intr), .axi_intr(axi_intr)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [127:0] xf(input logic [127:0] x);
    return {x[63:0], x[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  // Core stand-in: result appears C_LAT cycles after the core_din_vld cycle.
  logic [127:0] core_pipe [C_LAT];
  always @(posedge clk) begin
    core_pipe[0] <= xf(core_din);
    for (int i = 1; i < C_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_dout = core_pipe[C_LAT-1];

  int    errors = 0, checks = 0;
  int    cyc = 0, hs_cyc = 0, accepted = 0, out_beats = 0, sts_pkts = 0;
  int    mode_s2mm = 1, mode_sts = 1;
  bit    drv_done;
  beat_t exp_q[$];
  int    sts_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 2) ? ($urandom_range(0, 3) != 0) : (m == 1);
  endfunction

  task automatic send_packet(input int n, input logic [15:0] lk, input int gapmax,
                             input int exp_cnt, input bit close);
    beat_t e;
    int    t;
    bit    ok;
    for (int b = 0; b < n; b++) begin
      repeat ((gapmax > 0) ? $urandom_range(0, gapmax) : 0) begin
        m_axis_mm2s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      m_axis_mm2s_tdata  = {$urandom, $urandom, $urandom, $urandom};
      m_axis_mm2s_tkeep  = (b == n - 1) ? lk : 16'hffff;
      m_axis_mm2s_tlast  = close && (b == n - 1);
      m_axis_mm2s_tvalid = 1'b1;
      t = 0; ok = 1'b0;
      while (!ok && t < 3000) begin
        @(negedge clk);
        if (m_axis_mm2s_tready) ok = 1'b1; else t++;
      end
      chk("mm2s_accept", ok, 1'b1);
      if (ok) begin
        e.d = xf(m_axis_mm2s_tdata); e.k = m_axis_mm2s_tkeep; e.l = m_axis_mm2s_tlast;
        exp_q.push_back(e);
        accepted++;
        hs_cyc = cyc;
        if (close && b == n - 1) sts_q.push_back(exp_cnt);
      end
      @(posedge clk); #1;
      m_axis_mm2s_tvalid = 1'b0;
      m_axis_mm2s_tlast  = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || sts_q.size() != 0) && t < 20000) begin
      @(negedge clk); t++;
    end
    chk(nm, exp_q.size() + sts_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_driver(input string nm);
    int t = 0;
    while (!drv_done && t < 5000) begin @(posedge clk); t++; end
    chk(nm, drv_done, 1'b1);
    #1;
  endtask

  task automatic mon_s2mm();
    beat_t e;
    forever begin
      @(negedge clk);
      if (axi_resetn && s_axis_s2mm_tvalid && s_axis_s2mm_tready) begin
        out_beats++;
        chk("s2mm_beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("s2mm_tdata", s_axis_s2mm_tdata, e.d);
          chk("s2mm_tkeep", s_axis_s2mm_tkeep, e.k);
          chk("s2mm_tlast", s_axis_s2mm_tlast, e.l);
        end
      end
    end
  endtask

  task automatic mon_sts();
    int          wi = 0;
    bit          pend = 1'b0;
    logic [31:0] pd, ew;
    logic        pl;
    forever begin
      @(negedge clk);
      if (!axi_resetn) begin
        wi = 0; pend = 1'b0;
      end else begin
        if (pend) begin
          chk("sts_hold_tvalid", s_axis_s2mm_sts_tvalid, 1'b1);
          chk("sts_hold_tdata", s_axis_s2mm_sts_tdata, pd);
          chk("sts_hold_tlast", s_axis_s2mm_sts_tlast, pl);
        end
        pend = s_axis_s2mm_sts_tvalid && !s_axis_s2mm_sts_tready;
        pd = s_axis_s2mm_sts_tdata; pl = s_axis_s2mm_sts_tlast;
        if (s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready) begin
          chk("sts_tkeep", s_axis_s2mm_sts_tkeep, 4'hf);
          chk("sts_tlast", s_axis_s2mm_sts_tlast, wi == C_STS - 1);
          if (wi == 0) begin
            chk("sts_pkt_expected", sts_q.size() != 0, 1'b1);
            if (sts_q.size() != 0) begin
              ew = {4'h5, 3'b000, 1'b0, 24'(sts_q[0])};
              chk("sts_word0", s_axis_s2mm_sts_tdata, ew);
            end
          end else begin
            chk("sts_word_zero", s_axis_s2mm_sts_tdata, 32'h0);
          end
          if (wi == C_STS - 1) begin
            wi = 0; sts_pkts++;
            if (sts_q.size() != 0) void'(sts_q.pop_front());
          end else begin
            wi++;
          end
        end
      end
    end
  endtask

  initial begin
    pkt_vec_t    pv[5];
    intr_vec_t   iv[4];
    int          t, ob0, sp0, acc0, n, ec;
    logic [15:0] lk;

    axi_resetn = 1'b0;
    m_axis_mm2s_tdata = '0; m_axis_mm2s_tkeep = '0;
    m_axis_mm2s_tvalid = 1'b0; m_axis_mm2s_tlast = 1'b0;
    s2mm_intr = 1'b0; mm2s_intr = 1'b0;

    fork
      forever begin @(posedge clk); cyc++; end
      forever begin
        @(posedge clk); #1;
        s_axis_s2mm_tready     = rdy(mode_s2mm);
        s_axis_s2mm_sts_tready = rdy(mode_sts);
      end
      mon_s2mm();
      mon_sts();
      begin
        #(WD_CYCLES * 10);
        errors++;
        $display("FAIL watchdog: bench did not finish within %0d cycles", WD_CYCLES);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mm2s_tready", m_axis_mm2s_tready, 1'b0);
    chk("rst_core_din_vld", core_din_vld, 1'b0);
    chk("rst_core_din", core_din, '0);
    chk("rst_s2mm_tvalid", s_axis_s2mm_tvalid, 1'b0);
    chk("rst_sts_tvalid", s_axis_s2mm_sts_tvalid, 1'b0);

    iv[0] = '{1'b0, 1'b0, 1'b0}; iv[1] = '{1'b1, 1'b0, 1'b1};
    iv[2] = '{1'b0, 1'b1, 1'b1}; iv[3] = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      s2mm_intr = iv[i].a; mm2s_intr = iv[i].b; #1;
      chk("axi_intr", axi_intr, iv[i].y);
    end

    @(posedge clk); #1 axi_resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("tready_after_reset", m_axis_mm2s_tready, 1'b1);
    @(posedge clk); #1;

    // Single beat: core handoff, latency, status word0 = 0x5000_0010
    send_packet(1, 16'hffff, 0, 16, 1);
    @(negedge clk);
    chk("t1_core_din_vld", core_din_vld, 1'b1);
    chk("t1_core_din", core_din, m_axis_mm2s_tdata);
    @(negedge clk);
    chk("t1_core_din_vld_pulse", core_din_vld, 1'b0);
    t = 0;
    while (!s_axis_s2mm_tvalid && t < 100) begin @(negedge clk); t++; end
    chk("t1_latency", cyc - hs_cyc, C_LAT + 2);
    drain("t1_drain");

    // Table of packets with expected byte counts
    pv[0] = '{1, 16'hffff, 16};
    pv[1] = '{4, 16'h00ff, 56};
    pv[2] = '{3, 16'h0001, 33};
    pv[3] = '{2, 16'h0000, 16};
    pv[4] = '{6, 16'h8001, 82};
    for (int i = 0; i < 5; i++) begin
      send_packet(pv[i].n, pv[i].lk, 1, pv[i].cnt, 1);
      drain("tbl_drain");
    end

    // 300-beat packet against a stalled sink: credit caps acceptance at FIFO depth
    mode_s2mm = 0; drv_done = 1'b0; acc0 = accepted;
    fork
      begin send_packet(300, 16'hffff, 0, 4800, 1); drv_done = 1'b1; end
    join_none
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("t2_accepted", accepted - acc0, C_DEPTH);
    chk("t2_tready_low", m_axis_mm2s_tready, 1'b0);
    @(posedge clk); #1;
    mode_s2mm = 1;
    wait_driver("t2_driver_done");
    drain("t2_drain");

    // Five one-beat packets with status stalled: fifth tlast is held
    mode_sts = 0; drv_done = 1'b0; ob0 = out_beats; sp0 = sts_pkts;
    fork
      begin
        for (int i = 0; i < 5; i++) send_packet(1, 16'((1 << (i + 1)) - 1), 0, i + 1, 1);
        drv_done = 1'b1;
      end
    join_none
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("t3_delivered", out_beats - ob0, 4);
    chk("t3_fifth_held", s_axis_s2mm_tvalid, 1'b0);
    chk("t3_sts_pending", s_axis_s2mm_sts_tvalid, 1'b1);
    @(posedge clk); #1;
    mode_sts = 1;
    wait_driver("t3_driver_done");
    drain("t3_drain");
    chk("t3_sts_pkts", sts_pkts - sp0, 5);

    // Reset with beats buffered and in flight
    mode_s2mm = 0;
    send_packet(10, 16'hffff, 0, 0, 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("t5_valid_before_reset", s_axis_s2mm_tvalid, 1'b1);
    @(posedge clk); #1;
    send_packet(10, 16'hffff, 0, 0, 0);
    #2 axi_resetn = 1'b0;
    #1;
    chk("t5_rst_s2mm_tvalid", s_axis_s2mm_tvalid, 1'b0);
    chk("t5_rst_sts_tvalid", s_axis_s2mm_sts_tvalid, 1'b0);
    chk("t5_rst_mm2s_tready", m_axis_mm2s_tready, 1'b0);
    chk("t5_rst_core_din_vld", core_din_vld, 1'b0);
    exp_q.delete(); sts_q.delete();
    repeat (3) @(posedge clk);
    #1 axi_resetn = 1'b1;
    mode_s2mm = 1; ob0 = out_beats; sp0 = sts_pkts;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("t5_no_stale_beats", out_beats - ob0, 0);
    chk("t5_no_stale_sts", sts_pkts - sp0, 0);
    @(posedge clk); #1;
    send_packet(3, 16'h0f0f, 0, 40, 1);
    drain("t5_drain");

    // Random traffic with random backpressure on both sinks
    mode_s2mm = 2; mode_sts = 2;
    for (int p = 0; p < 1000; p++) begin
      n  = $urandom_range(1, 4);
      lk = 16'($urandom_range(0, 65535));
      ec = 16 * (n - 1) + $countones(lk);
      send_packet(n, lk, 2, ec, 1);
    end
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
